branch_redirect_unit: RTL and testbench
=======================================

Name: branch_redirect_unit

Overview:
Consumer end of the branch-resolution interface. Captures resolved branch outcomes, keyed by ROB index, as they arrive from the branch execution unit. When the ROB retires a branch, this block releases the stored outcome. For a taken branch it drives a flush pulse to the ROB and reservation stations and a held redirect to fetch.

Parameters:
ROB_ENTRIES, 16, number of ROB slots (one outcome entry per slot)
IDX_W, 4, ROB index width (log2 ROB_ENTRIES)
PC_W, 16, branch target width

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
br_valid  in  1  branch unit result valid this cycle
br_rob_index  in  IDX_W  ROB slot of resolved branch
br_target  in  PC_W  branch target
br_taken  in  1  branch condition outcome
commit_valid  in  1  ROB retires head entry this cycle
commit_is_branch  in  1  retiring entry is a branch
commit_rob_index  in  IDX_W  ROB slot being retired
head_ready  out  1  ROB may retire commit_rob_index (combinational)
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  PC_W  fetch target while redirect_valid
redirect_ready  in  1  fetch accepts redirect
flush  out  1  one-cycle pulse: squash all in-flight work
dup_err  out  1  sticky: result written to an already-resolved slot
taken_count  out  16  wrapping count of redirects issued

Behaviour:
- Reset (rst_n=0 at edge): all resolved bits=0, state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, dup_err=0, taken_count=0. Reset mid-redirect aborts the redirect; no flush is emitted.
- Table: per slot resolved, taken, target.
  - br_valid in cycle N writes slot br_rob_index and sets resolved; the write is visible at N+1.
  - No same-cycle bypass to head_ready.
- Duplicate write: br_valid to a slot with resolved=1 sets dup_err (sticky until reset); the new data overwrites the old.
- head_ready = (state==IDLE) && (!commit_is_branch || resolved[commit_rob_index]).
- Commit while the head slot is unresolved (commit_valid & commit_is_branch & !head_ready) is a protocol violation and is ignored: no state change.
- Branch commit in IDLE (commit_valid & commit_is_branch & resolved) in cycle N clears that slot's resolved bit.
  - Taken: state→REDIRECT; at N+1 redirect_valid=1, redirect_pc=target, flush=1 for cycle N+1 only; taken_count increments.
  - Not taken: no other effect.
- Non-branch commit: no effect.
- REDIRECT state:
  - redirect_valid and redirect_pc hold until redirect_ready=1.
  - Handshake cycle: state→IDLE and redirect_valid=0 next cycle.
  - Minimum REDIRECT duration is 1 cycle (redirect_ready already high at N+1).
- Flush table clear: during the flush cycle, all resolved bits clear at the end of that cycle. The clear has priority over a simultaneous br_valid write.
- br_valid in any REDIRECT cycle is dropped (wrong-path result). No write, no dup_err.
- Simultaneous br_valid and commit to the same slot in IDLE: the commit sees the old table contents. If the commit consumes the slot, the clear wins and the write is discarded. If the commit is ignored (unresolved), the write proceeds.
- taken_count wraps at 16'hFFFF→0.
- FSM: IDLE, REDIRECT. An implicit FLUSH sub-cycle is flagged by a registered flush bit.

Decomposition:
- Shared package: IDX_W, PC_W, ROB_ENTRIES constants; FSM state encoding (IDLE=0, REDIRECT=1).
- The branch opcode constants are already shared with the branch unit and belong in the same package.
- One sub-module is natural: branch_outcome_table, holding the resolved/taken/target arrays with write, clear-one and clear-all ports and a combinational read.

Test Plan:
- Not-taken path: reset; br_valid slot 3 taken=0 target=16'h0040; next cycle commit slot 3 branch → head_ready=1, no redirect_valid, no flush, taken_count=0, slot 3 resolved=0.
- Taken path: br_valid slot 5 taken=1 target=16'h01A0; commit slot 5 at N → at N+1 redirect_valid=1, redirect_pc=16'h01A0, flush=1; flush=0 at N+2; taken_count=1.
- Fetch backpressure: taken redirect with redirect_ready=0 for 4 cycles then 1 → redirect_valid held 5 cycles, head_ready=0 throughout, IDLE after the handshake.
- Unresolved head: commit slot 7 branch with slot 7 unresolved → head_ready=0, no state change; br_valid slot 7 at N → head_ready=1 at N+1.
- Flush clears table and drops wrong-path results: resolve slots 2 and 9, taken commit slot 1 → after flush, slots 2 and 9 are unresolved; br_valid during REDIRECT leaves the table unchanged and dup_err=0.
- Duplicate and reset: br_valid slot 4 twice → dup_err=1; assert rst_n=0 during REDIRECT → next cycle redirect_valid=0, dup_err=0, taken_count=0.

Source files
------------

// File: rtl/branch_redirect_unit_pkg.sv
// Shared constants, FSM encoding and payload types for the branch redirect unit.
package branch_redirect_unit_pkg;

    localparam int unsigned ROB_ENTRIES = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned PC_W        = 16;
    localparam int unsigned CNT_W       = 16;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    // Branch opcodes shared with the branch execution unit.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } br_op_t;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] target;
    } outcome_t;

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Branch-result, commit and fetch-redirect signals of the branch redirect unit.
interface branch_redirect_unit_if;
    import branch_redirect_unit_pkg::*;

    logic             br_valid;
    logic [IDX_W-1:0] br_rob_index;
    logic [PC_W-1:0]  br_target;
    logic             br_taken;
    logic             commit_valid;
    logic             commit_is_branch;
    logic [IDX_W-1:0] commit_rob_index;
    logic             head_ready;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             redirect_ready;
    logic             flush;
    logic             dup_err;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output br_valid, br_rob_index, br_target, br_taken,
        output commit_valid, commit_is_branch, commit_rob_index, redirect_ready,
        input  head_ready, redirect_valid, redirect_pc, flush, dup_err, taken_count
    );

    modport slave (
        input  br_valid, br_rob_index, br_target, br_taken,
        input  commit_valid, commit_is_branch, commit_rob_index, redirect_ready,
        output head_ready, redirect_valid, redirect_pc, flush, dup_err, taken_count
    );

endinterface

// File: rtl/branch_redirect_unit_outcome_table.sv
// Per-ROB-slot resolved/taken/target storage with write, clear-one, clear-all
// and a combinational read port.
module branch_outcome_table
    import branch_redirect_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  outcome_t         wr_data,
    input  logic             clr_one,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             clr_all,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_resolved,
    output outcome_t         rd_data,
    output logic             wr_resolved
);

    logic [ROB_ENTRIES-1:0] resolved;
    outcome_t               entry [ROB_ENTRIES];

    // Clear-one is ordered after the write so it wins on a same-slot collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resolved <= '0;
        end else if (clr_all) begin
            resolved <= '0;
        end else begin
            if (wr_en)   resolved[wr_idx]  <= 1'b1;
            if (clr_one) resolved[clr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr_all) entry[wr_idx] <= wr_data;
    end

    assign rd_resolved = resolved[rd_idx];
    assign rd_data     = entry[rd_idx];
    assign wr_resolved = resolved[wr_idx];

endmodule

// File: rtl/branch_redirect_unit.sv
// Releases resolved branch outcomes at retirement and turns taken branches into
// a one-cycle flush plus a held fetch redirect.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    branch_redirect_unit_if.slave   bus
);

    logic [0:0]       state, state_nxt;
    logic             redirect_valid, redirect_valid_nxt;
    logic [PC_W-1:0]  redirect_pc, redirect_pc_nxt;
    logic             flush, flush_nxt;
    logic             dup_err, dup_err_nxt;
    logic [CNT_W-1:0] taken_count, taken_count_nxt;

    logic             idle;
    logic             consume;
    logic             wr_en;
    logic             rd_resolved;
    logic             wr_resolved;
    outcome_t         rd_data;
    outcome_t         wr_data;

    assign idle    = (state == ST_IDLE);
    assign wr_en   = bus.br_valid && idle;
    assign consume = idle && bus.commit_valid && bus.commit_is_branch && rd_resolved;
    assign wr_data = '{taken: bus.br_taken, target: bus.br_target};

    branch_outcome_table u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_idx      (bus.br_rob_index),
        .wr_data     (wr_data),
        .clr_one     (consume),
        .clr_idx     (bus.commit_rob_index),
        .clr_all     (flush),
        .rd_idx      (bus.commit_rob_index),
        .rd_resolved (rd_resolved),
        .rd_data     (rd_data),
        .wr_resolved (wr_resolved)
    );

    always_comb begin
        state_nxt          = state;
        redirect_valid_nxt = redirect_valid;
        redirect_pc_nxt    = redirect_pc;
        flush_nxt          = 1'b0;
        dup_err_nxt        = dup_err;
        taken_count_nxt    = taken_count;
        if (state == ST_IDLE) begin
            if (consume && rd_data.taken) begin
                state_nxt          = ST_REDIRECT;
                redirect_valid_nxt = 1'b1;
                redirect_pc_nxt    = rd_data.target;
                flush_nxt          = 1'b1;
                taken_count_nxt    = taken_count + CNT_W'(1);
            end
        end else begin
            if (bus.redirect_ready) begin
                state_nxt          = ST_IDLE;
                redirect_valid_nxt = 1'b0;
            end
        end
        if (wr_en && wr_resolved) dup_err_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            dup_err        <= 1'b0;
            taken_count    <= '0;
        end else begin
            state          <= state_nxt;
            redirect_valid <= redirect_valid_nxt;
            redirect_pc    <= redirect_pc_nxt;
            flush          <= flush_nxt;
            dup_err        <= dup_err_nxt;
            taken_count    <= taken_count_nxt;
        end
    end

    assign bus.head_ready     = idle && (!bus.commit_is_branch || rd_resolved);
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.flush          = flush;
    assign bus.dup_err        = dup_err;
    assign bus.taken_count    = taken_count;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed and randomized checks of branch_redirect_unit against a cycle-level
// model of the outcome table and redirect handshake.
module tb_branch_redirect_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    branch_redirect_unit_if bus ();

    branch_redirect_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state
    bit          m_res [16];
    bit          m_tk  [16];
    logic [15:0] m_tgt [16];
    bit          m_busy;
    bit          m_rv;
    logic [15:0] m_pc;
    bit          m_flush;
    bit          m_dup;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_res[i] = 1'b0;
        m_busy = 1'b0; m_rv = 1'b0; m_pc = '0; m_flush = 1'b0; m_dup = 1'b0; m_cnt = '0;
    endfunction

    function automatic bit model_head_ready(input bit cib, input int cidx);
        return !m_busy && (!cib || m_res[cidx]);
    endfunction

    // One clock of the spec rules, evaluated from pre-edge contents.
    function automatic void model_step(input bit rn, input bit bv, input int bidx,
                                       input logic [15:0] btgt, input bit btk,
                                       input bit cv, input bit cib, input int cidx,
                                       input bit rr);
        bit take, consume, nflush;
        logic [15:0] ctgt;
        if (!rn) begin
            model_reset();
            return;
        end
        consume = !m_busy && cv && cib && m_res[cidx];
        take    = consume && m_tk[cidx];
        ctgt    = m_tgt[cidx];
        nflush  = take;
        if (!m_busy && bv && m_res[bidx]) m_dup = 1'b1;
        if (m_flush) begin
            for (int i = 0; i < 16; i++) m_res[i] = 1'b0;
        end else begin
            if (!m_busy && bv) begin
                m_res[bidx] = 1'b1; m_tk[bidx] = btk; m_tgt[bidx] = btgt;
            end
            if (consume) m_res[cidx] = 1'b0;
        end
        if (take) begin
            m_busy = 1'b1; m_rv = 1'b1; m_pc = ctgt; m_cnt = m_cnt + 16'd1;
        end else if (m_busy && rr) begin
            m_busy = 1'b0; m_rv = 1'b0;
        end
        m_flush = nflush;
    endfunction

    task automatic cycle(input bit rn, input bit bv, input int bidx, input logic [15:0] btgt,
                         input bit btk, input bit cv, input bit cib, input int cidx, input bit rr);
        @(negedge clk);
        rst_n                = rn;
        bus.br_valid         = bv;
        bus.br_rob_index     = 4'(bidx);
        bus.br_target        = btgt;
        bus.br_taken         = btk;
        bus.commit_valid     = cv;
        bus.commit_is_branch = cib;
        bus.commit_rob_index = 4'(cidx);
        bus.redirect_ready   = rr;
        #1;
        if (rn) check("head_ready", 32'(bus.head_ready), 32'(model_head_ready(cib, cidx)));
        model_step(rn, bv, bidx, btgt, btk, cv, cib, cidx, rr);
        @(posedge clk);
        #1;
        check("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
        check("redirect_pc",    32'(bus.redirect_pc),    32'(m_pc));
        check("flush",          32'(bus.flush),          32'(m_flush));
        check("dup_err",        32'(bus.dup_err),        32'(m_dup));
        check("taken_count",    32'(bus.taken_count),    32'(m_cnt));
    endtask

    task automatic idle_cycle(input bit rr);
        cycle(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, rr);
    endtask

    initial begin
        model_reset();
        cycle(1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        cycle(1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("rst_count", 32'(bus.taken_count), 32'h0);

        // Not-taken path
        cycle(1'b1, 1'b1, 3, 16'h0040, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        cycle(1'b1, 1'b0, 0, 16'h0,    1'b0, 1'b1, 1'b1, 3, 1'b1);
        check("nt_no_redirect", 32'(bus.redirect_valid), 32'h0);
        cycle(1'b1, 1'b0, 0, 16'h0,    1'b0, 1'b0, 1'b1, 3, 1'b1);
        check("nt_slot3_cleared", 32'(bus.head_ready), 32'h0);

        // Taken path
        cycle(1'b1, 1'b1, 5, 16'h01A0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        cycle(1'b1, 1'b0, 0, 16'h0,    1'b0, 1'b1, 1'b1, 5, 1'b1);
        check("tk_pc", 32'(bus.redirect_pc), 32'h01A0);
        check("tk_flush", 32'(bus.flush), 32'h1);
        idle_cycle(1'b1);
        check("tk_flush_gone", 32'(bus.flush), 32'h0);
        check("tk_count", 32'(bus.taken_count), 32'h1);

        // Fetch backpressure
        cycle(1'b1, 1'b1, 6, 16'h0BEE, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 16'h0,    1'b0, 1'b1, 1'b1, 6, 1'b0);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);
        check("bp_held", 32'(bus.redirect_valid), 32'h1);
        idle_cycle(1'b1);
        check("bp_released", 32'(bus.redirect_valid), 32'h0);

        // Unresolved head, then resolve it
        cycle(1'b1, 1'b0, 0, 16'h0,    1'b0, 1'b1, 1'b1, 7, 1'b1);
        cycle(1'b1, 1'b1, 7, 16'h0300, 1'b0, 1'b1, 1'b1, 7, 1'b1);
        cycle(1'b1, 1'b0, 0, 16'h0,    1'b0, 1'b1, 1'b1, 7, 1'b1);

        // Flush clears table; wrong-path results dropped
        cycle(1'b1, 1'b1, 2, 16'h0022, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 9, 16'h0099, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 1, 16'h0011, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 16'h0,    1'b0, 1'b1, 1'b1, 1, 1'b0);
        cycle(1'b1, 1'b1, 4, 16'h0444, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 4, 16'h0444, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        check("fl_no_dup", 32'(bus.dup_err), 32'h0);
        cycle(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
        cycle(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b1, 9, 1'b1);
        cycle(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b1, 4, 1'b1);

        // Duplicate write, then reset mid-redirect
        cycle(1'b1, 1'b1, 4, 16'h0040, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 4, 16'h0048, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("dup_set", 32'(bus.dup_err), 32'h1);
        cycle(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        check("dup_overwrite_pc", 32'(bus.redirect_pc), 32'h0048);
        cycle(1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("rst_mid_rv", 32'(bus.redirect_valid), 32'h0);
        check("rst_mid_flush", 32'(bus.flush), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(199) != 0),
                  ($urandom_range(1) == 1), int'($urandom_range(15)),
                  16'($urandom), ($urandom_range(1) == 1),
                  ($urandom_range(1) == 1), ($urandom_range(9) < 7),
                  int'($urandom_range(15)), ($urandom_range(2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
